// File: rtl/cpl_arb_pkg.sv
// rtl/cpl_arb_pkg.sv - shared types, UR entry layout and packing helper for the completion arbiter
package cpl_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE       = 3'd0,
    ARB_RD         = 3'd1,
    ARB_UR         = 3'd2,
    ARB_UR_RELEASE = 3'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_UR = 1'b1
  } grant_src_e;

  localparam int UR_ENTRY_W = 41;

  localparam int UR_TAG_OFF   = 0;
  localparam int UR_TAG_W     = 8;
  localparam int UR_LADDR_OFF = 8;
  localparam int UR_LADDR_W   = 7;
  localparam int UR_FBE_OFF   = 15;
  localparam int UR_FBE_W     = 4;
  localparam int UR_RID_OFF   = 19;
  localparam int UR_RID_W     = 16;
  localparam int UR_TC_OFF    = 35;
  localparam int UR_TC_W      = 3;
  localparam int UR_ATTR_OFF  = 38;
  localparam int UR_ATTR_W    = 3;

  function automatic logic [UR_ENTRY_W-1:0] pack_ur_entry(
    input logic [7:0]  tag,
    input logic [6:0]  lower_addr,
    input logic [3:0]  first_be,
    input logic [15:0] requester_id,
    input logic [2:0]  tc,
    input logic [2:0]  attr
  );
    return {attr, tc, requester_id, first_be, lower_addr, tag};
  endfunction

endpackage

// File: rtl/ur_req_fifo.sv
// rtl/ur_req_fifo.sv - first-word-fall-through queue of pending UR requests
module ur_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push_valid,
  output logic                   o_push_ready,
  input  logic [WIDTH-1:0]       i_push_data,
  output logic                   o_head_valid,
  output logic [WIDTH-1:0]       o_head_data,
  input  logic                   i_pop,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full       = (r_count == FULL_COUNT);
  assign o_push_ready = !w_full && !i_rst;
  assign o_head_valid = (r_count != '0);
  assign o_head_data  = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = i_pop && o_head_valid;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpl_req_arbiter.sv
// rtl/cpl_req_arbiter.sv - alternating arbiter between read completions and queued UR completions
module cpl_req_arbiter
  import cpl_arb_pkg::*;
#(
  parameter int TCQ           = 1,
  parameter int UR_FIFO_DEPTH = 4
) (
  input  logic                           axis_clk,
  input  logic                           axis_rst,
  input  logic                           rd_cpl_valid,
  output logic                           rd_cpl_ready,
  input  logic [63:0]                    rd_cpl_data,
  input  logic                           ur_in_valid,
  output logic                           ur_in_ready,
  input  logic [7:0]                     ur_in_tag,
  input  logic [6:0]                     ur_in_lower_addr,
  input  logic [3:0]                     ur_in_first_be,
  input  logic [15:0]                    ur_in_requester_id,
  input  logic [2:0]                     ur_in_tc,
  input  logic [2:0]                     ur_in_attr,
  output logic                           axi_cpld_valid,
  input  logic                           axi_cpld_ready,
  output logic [63:0]                    axi_cpld_data,
  output logic                           completion_ur_req,
  input  logic                           completion_ur_done,
  output logic [7:0]                     completion_ur_tag,
  output logic [6:0]                     completion_ur_lower_addr,
  output logic [3:0]                     completion_ur_first_be,
  output logic [15:0]                    completion_ur_requester_id,
  output logic [2:0]                     completion_ur_tc,
  output logic [2:0]                     completion_ur_attr,
  output logic [$clog2(UR_FIFO_DEPTH):0] ur_fifo_count
);

  if (UR_FIFO_DEPTH < 2 || UR_FIFO_DEPTH > 16 ||
      (UR_FIFO_DEPTH & (UR_FIFO_DEPTH - 1)) != 0 || TCQ < 0) begin : g_bad_params
    $error("cpl_req_arbiter: unsupported parameter set");
  end

  arb_state_e            r_state;
  arb_state_e            w_next_state;
  grant_src_e            r_last_grant;
  logic                  r_ur_req;
  logic                  w_rd_xfer;
  logic                  w_ur_pop;
  logic                  w_ur_avail;
  logic                  w_head_valid;
  logic [UR_ENTRY_W-1:0] w_head;
  logic [UR_ENTRY_W-1:0] w_push_entry;

  assign w_push_entry = pack_ur_entry(ur_in_tag, ur_in_lower_addr, ur_in_first_be,
                                      ur_in_requester_id, ur_in_tc, ur_in_attr);

  ur_req_fifo #(
    .DEPTH (UR_FIFO_DEPTH),
    .WIDTH (UR_ENTRY_W)
  ) u_ur_fifo (
    .i_clk        (axis_clk),
    .i_rst        (axis_rst),
    .i_push_valid (ur_in_valid),
    .o_push_ready (ur_in_ready),
    .i_push_data  (w_push_entry),
    .o_head_valid (w_head_valid),
    .o_head_data  (w_head),
    .i_pop        (w_ur_pop),
    .o_count      (ur_fifo_count)
  );

  // A UR grant is withheld while the generator still holds done from the previous one.
  assign w_ur_avail = w_head_valid && !completion_ur_done;

  always_comb begin
    w_next_state = r_state;
    w_rd_xfer    = 1'b0;
    w_ur_pop     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (rd_cpl_valid && w_ur_avail) begin
          w_next_state = (r_last_grant == GRANT_UR) ? ARB_RD : ARB_UR;
        end else if (rd_cpl_valid) begin
          w_next_state = ARB_RD;
        end else if (w_ur_avail) begin
          w_next_state = ARB_UR;
        end
      end
      ARB_RD: begin
        w_rd_xfer = rd_cpl_valid && axi_cpld_ready;
        if (w_rd_xfer) begin
          w_next_state = ARB_IDLE;
        end
      end
      ARB_UR: begin
        if (completion_ur_done) begin
          w_ur_pop     = 1'b1;
          w_next_state = ARB_UR_RELEASE;
        end
      end
      ARB_UR_RELEASE: begin
        if (!completion_ur_done) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= GRANT_UR;
      r_ur_req     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_ur_req <= (w_next_state == ARB_UR);
      if (w_rd_xfer) begin
        r_last_grant <= GRANT_RD;
      end else if (w_ur_pop) begin
        r_last_grant <= GRANT_UR;
      end
    end
  end

  assign axi_cpld_valid = (r_state == ARB_RD) && rd_cpl_valid;
  assign rd_cpl_ready   = (r_state == ARB_RD) && axi_cpld_ready;
  assign axi_cpld_data  = rd_cpl_data;

  // Head only moves on pop, so the fields hold steady for the whole grant.
  assign completion_ur_req          = r_ur_req;
  assign completion_ur_tag          = w_head[UR_TAG_OFF   +: UR_TAG_W];
  assign completion_ur_lower_addr   = w_head[UR_LADDR_OFF +: UR_LADDR_W];
  assign completion_ur_first_be     = w_head[UR_FBE_OFF   +: UR_FBE_W];
  assign completion_ur_requester_id = w_head[UR_RID_OFF   +: UR_RID_W];
  assign completion_ur_tc           = w_head[UR_TC_OFF    +: UR_TC_W];
  assign completion_ur_attr         = w_head[UR_ATTR_OFF  +: UR_ATTR_W];

endmodule

// File: tb/tb_cpl_req_arbiter.sv
// tb/tb_cpl_req_arbiter.sv - directed self-checking bench for cpl_req_arbiter
module tb_cpl_req_arbiter;
  import cpl_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_cpl_valid;
  logic        rd_cpl_ready;
  logic [63:0] rd_cpl_data;
  logic        ur_in_valid;
  logic        ur_in_ready;
  logic [7:0]  ur_in_tag;
  logic [6:0]  ur_in_lower_addr;
  logic [3:0]  ur_in_first_be;
  logic [15:0] ur_in_requester_id;
  logic [2:0]  ur_in_tc;
  logic [2:0]  ur_in_attr;
  logic        axi_cpld_valid;
  logic        axi_cpld_ready;
  logic [63:0] axi_cpld_data;
  logic        completion_ur_req;
  logic        completion_ur_done;
  logic [7:0]  completion_ur_tag;
  logic [6:0]  completion_ur_lower_addr;
  logic [3:0]  completion_ur_first_be;
  logic [15:0] completion_ur_requester_id;
  logic [2:0]  completion_ur_tc;
  logic [2:0]  completion_ur_attr;
  logic [2:0]  ur_fifo_count;

  int checks = 0;
  int passed = 0;

  int          grant_log[$];
  int          rd_beat_count = 0;
  int          rd_ready_pulses = 0;
  int          overlap_count = 0;
  logic [63:0] last_beat_data = '0;

  always #5 clk = ~clk;

  cpl_req_arbiter #(.TCQ(1), .UR_FIFO_DEPTH(4)) dut (
    .axis_clk                   (clk),
    .axis_rst                   (rst),
    .rd_cpl_valid               (rd_cpl_valid),
    .rd_cpl_ready               (rd_cpl_ready),
    .rd_cpl_data                (rd_cpl_data),
    .ur_in_valid                (ur_in_valid),
    .ur_in_ready                (ur_in_ready),
    .ur_in_tag                  (ur_in_tag),
    .ur_in_lower_addr           (ur_in_lower_addr),
    .ur_in_first_be             (ur_in_first_be),
    .ur_in_requester_id         (ur_in_requester_id),
    .ur_in_tc                   (ur_in_tc),
    .ur_in_attr                 (ur_in_attr),
    .axi_cpld_valid             (axi_cpld_valid),
    .axi_cpld_ready             (axi_cpld_ready),
    .axi_cpld_data              (axi_cpld_data),
    .completion_ur_req          (completion_ur_req),
    .completion_ur_done         (completion_ur_done),
    .completion_ur_tag          (completion_ur_tag),
    .completion_ur_lower_addr   (completion_ur_lower_addr),
    .completion_ur_first_be     (completion_ur_first_be),
    .completion_ur_requester_id (completion_ur_requester_id),
    .completion_ur_tc           (completion_ur_tc),
    .completion_ur_attr         (completion_ur_attr),
    .ur_fifo_count              (ur_fifo_count)
  );

  // Downstream grant monitor: RD beats logged as -1, UR grants by tag.
  always @(negedge clk) begin
    if (axi_cpld_valid && axi_cpld_ready) begin
      grant_log.push_back(-1);
      rd_beat_count  <= rd_beat_count + 1;
      last_beat_data <= axi_cpld_data;
    end
    if (completion_ur_req && completion_ur_done) grant_log.push_back(int'(completion_ur_tag));
    if (rd_cpl_ready && rd_cpl_valid) rd_ready_pulses <= rd_ready_pulses + 1;
    if (axi_cpld_valid && completion_ur_req) overlap_count <= overlap_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ur(input logic [7:0] tag, input logic [15:0] rid);
    ur_in_valid        = 1'b1;
    ur_in_tag          = tag;
    ur_in_requester_id = rid;
    tick();
    ur_in_valid = 1'b0;
  endtask

  task automatic responder(input int stop_size, input int rd_target, input int budget);
    int cyc = 0;
    while (grant_log.size() < stop_size && cyc < budget) begin
      rd_cpl_valid       = (rd_beat_count < rd_target);
      rd_cpl_data        = 64'hD000 + 64'(rd_beat_count);
      axi_cpld_ready     = 1'b1;
      completion_ur_done = completion_ur_req;
      tick();
      cyc++;
    end
    rd_cpl_valid       = 1'b0;
    axi_cpld_ready     = 1'b0;
    completion_ur_done = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_cpl_valid = 1'b1; axi_cpld_ready = 1'b1; ur_in_valid = 1'b1;
    tick(); tick();
    checks++; if (axi_cpld_valid !== 1'b0) $display("FAIL rst_cpld_valid: got %b expected 0", axi_cpld_valid); else passed++;
    checks++; if (rd_cpl_ready !== 1'b0) $display("FAIL rst_rd_ready: got %b expected 0", rd_cpl_ready); else passed++;
    checks++; if (ur_in_ready !== 1'b0) $display("FAIL rst_ur_in_ready: got %b expected 0", ur_in_ready); else passed++;
    checks++; if (completion_ur_req !== 1'b0) $display("FAIL rst_ur_req: got %b expected 0", completion_ur_req); else passed++;
    checks++; if (ur_fifo_count !== 3'd0) $display("FAIL rst_count: got %0d expected 0", ur_fifo_count); else passed++;
    rd_cpl_valid = 1'b0; axi_cpld_ready = 1'b0; ur_in_valid = 1'b0; rst = 1'b0;
    #1;
    checks++; if (ur_in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", ur_in_ready); else passed++;
    checks++; if (dut.r_state !== ARB_IDLE) $display("FAIL rst_state: got %0d expected %0d", dut.r_state, ARB_IDLE); else passed++;
  endtask

  task automatic test_single_read();
    int base_beats = rd_beat_count;
    int base_pulses = rd_ready_pulses;
    rd_cpl_valid = 1'b1; rd_cpl_data = 64'h0123_4567_89AB_CDEF; axi_cpld_ready = 1'b0;
    tick();
    checks++; if (axi_cpld_valid !== 1'b1) $display("FAIL rd_grant_valid: got %b expected 1", axi_cpld_valid); else passed++;
    checks++; if (rd_cpl_ready !== 1'b0) $display("FAIL rd_ready_stalled: got %b expected 0", rd_cpl_ready); else passed++;
    tick();
    axi_cpld_ready = 1'b1;
    #1;
    checks++; if (rd_cpl_ready !== 1'b1) $display("FAIL rd_ready_pass: got %b expected 1", rd_cpl_ready); else passed++;
    checks++; if (axi_cpld_data !== 64'h0123_4567_89AB_CDEF) $display("FAIL rd_data: got %h expected 0123456789abcdef", axi_cpld_data); else passed++;
    tick();
    rd_cpl_valid = 1'b0; axi_cpld_ready = 1'b0;
    tick();
    checks++; if (rd_beat_count - base_beats !== 1) $display("FAIL rd_beats: got %0d expected 1", rd_beat_count - base_beats); else passed++;
    checks++; if (last_beat_data !== 64'h0123_4567_89AB_CDEF) $display("FAIL rd_beat_data: got %h expected 0123456789abcdef", last_beat_data); else passed++;
    checks++; if (rd_ready_pulses - base_pulses !== 1) $display("FAIL rd_ready_pulses: got %0d expected 1", rd_ready_pulses - base_pulses); else passed++;
    checks++; if (dut.r_state !== ARB_IDLE) $display("FAIL rd_back_idle: got %0d expected %0d", dut.r_state, ARB_IDLE); else passed++;
  endtask

  task automatic test_single_ur();
    push_ur(8'h5A, 16'hBEEF);
    checks++; if (ur_fifo_count !== 3'd1) $display("FAIL ur_count_push: got %0d expected 1", ur_fifo_count); else passed++;
    tick();
    checks++; if (completion_ur_req !== 1'b1) $display("FAIL ur_req_rise: got %b expected 1", completion_ur_req); else passed++;
    checks++; if ({completion_ur_tag, completion_ur_requester_id} !== 24'h5ABEEF)
      $display("FAIL ur_fields: got %h expected 5abeef", {completion_ur_tag, completion_ur_requester_id}); else passed++;
    checks++; if ({completion_ur_lower_addr, completion_ur_first_be, completion_ur_tc, completion_ur_attr} !== {7'h15, 4'hC, 3'd2, 3'd5})
      $display("FAIL ur_misc_fields: got %h expected %h", {completion_ur_lower_addr, completion_ur_first_be, completion_ur_tc, completion_ur_attr}, {7'h15, 4'hC, 3'd2, 3'd5}); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({completion_ur_req, completion_ur_tag, completion_ur_requester_id} !== {1'b1, 24'h5ABEEF})
        $display("FAIL ur_stable_%0d: got %h expected 15abeef", i, {completion_ur_req, completion_ur_tag, completion_ur_requester_id}); else passed++;
    end
    completion_ur_done = 1'b1;
    tick();
    checks++; if (completion_ur_req !== 1'b0) $display("FAIL ur_req_drop: got %b expected 0", completion_ur_req); else passed++;
    checks++; if (ur_fifo_count !== 3'd0) $display("FAIL ur_count_pop: got %0d expected 0", ur_fifo_count); else passed++;
    push_ur(8'h33, 16'h1234);
    checks++; if (ur_fifo_count !== 3'd1) $display("FAIL ur_count_second: got %0d expected 1", ur_fifo_count); else passed++;
    checks++; if (completion_ur_req !== 1'b0) $display("FAIL ur_no_rereq_a: got %b expected 0", completion_ur_req); else passed++;
    tick();
    checks++; if (completion_ur_req !== 1'b0) $display("FAIL ur_no_rereq_b: got %b expected 0", completion_ur_req); else passed++;
    completion_ur_done = 1'b0;
    tick();
    checks++; if (completion_ur_req !== 1'b0) $display("FAIL ur_release_idle: got %b expected 0", completion_ur_req); else passed++;
    tick();
    checks++; if ({completion_ur_req, completion_ur_tag} !== 9'h133) $display("FAIL ur_second_grant: got %h expected 133", {completion_ur_req, completion_ur_tag}); else passed++;
    completion_ur_done = 1'b1;
    tick();
    completion_ur_done = 1'b0;
    checks++; if (ur_fifo_count !== 3'd0) $display("FAIL ur_second_pop: got %0d expected 0", ur_fifo_count); else passed++;
    tick();
  endtask

  task automatic test_contention();
    int base = grant_log.size();
    int exp_log[5] = '{-1, 1, -1, 2, 3};
    rd_cpl_valid = 1'b1; rd_cpl_data = 64'hD0; axi_cpld_ready = 1'b0;
    tick();
    push_ur(8'h01, 16'h0001);
    push_ur(8'h02, 16'h0002);
    push_ur(8'h03, 16'h0003);
    checks++; if (ur_fifo_count !== 3'd3) $display("FAIL cont_count: got %0d expected 3", ur_fifo_count); else passed++;
    responder(base + 5, rd_beat_count + 2, 80);
    checks++; if (grant_log.size() - base !== 5) $display("FAIL cont_grants: got %0d expected 5", grant_log.size() - base); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (base + i < grant_log.size()) begin
        checks++; if (grant_log[base + i] !== exp_log[i])
          $display("FAIL cont_order_%0d: got %0d expected %0d", i, grant_log[base + i], exp_log[i]); else passed++;
      end
    end
    checks++; if (overlap_count !== 0) $display("FAIL cont_overlap: got %0d expected 0", overlap_count); else passed++;
    checks++; if (ur_fifo_count !== 3'd0) $display("FAIL cont_drained: got %0d expected 0", ur_fifo_count); else passed++;
  endtask

  task automatic test_full_queue();
    int base = grant_log.size();
    for (int i = 0; i < 4; i++) begin
      ur_in_valid = 1'b1; ur_in_tag = 8'hA0 + 8'(i); ur_in_requester_id = 16'hF000;
      #1;
      checks++; if (ur_in_ready !== 1'b1) $display("FAIL full_ready_%0d: got %b expected 1", i, ur_in_ready); else passed++;
      tick();
    end
    ur_in_tag = 8'hA4;
    checks++; if (ur_fifo_count !== 3'd4) $display("FAIL full_count: got %0d expected 4", ur_fifo_count); else passed++;
    checks++; if (ur_in_ready !== 1'b0) $display("FAIL full_backpressure: got %b expected 0", ur_in_ready); else passed++;
    tick(); tick();
    checks++; if (ur_fifo_count !== 3'd4) $display("FAIL full_held: got %0d expected 4", ur_fifo_count); else passed++;
    checks++; if ({completion_ur_req, completion_ur_tag} !== 9'h1A0) $display("FAIL full_head: got %h expected 1a0", {completion_ur_req, completion_ur_tag}); else passed++;
    completion_ur_done = 1'b1;
    tick();
    completion_ur_done = 1'b0;
    checks++; if (ur_fifo_count !== 3'd3) $display("FAIL full_after_pop: got %0d expected 3", ur_fifo_count); else passed++;
    checks++; if (ur_in_ready !== 1'b1) $display("FAIL full_ready_again: got %b expected 1", ur_in_ready); else passed++;
    tick();
    ur_in_valid = 1'b0;
    checks++; if (ur_fifo_count !== 3'd4) $display("FAIL full_fifth: got %0d expected 4", ur_fifo_count); else passed++;
    responder(base + 5, 0, 80);
    checks++; if (grant_log.size() - base !== 5) $display("FAIL full_grants: got %0d expected 5", grant_log.size() - base); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (base + i < grant_log.size()) begin
        checks++; if (grant_log[base + i] !== 32'hA0 + i)
          $display("FAIL full_order_%0d: got %0h expected %0h", i, grant_log[base + i], 32'hA0 + i); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_ur();
    push_ur(8'hB0, 16'h0B00);
    push_ur(8'hB1, 16'h0B01);
    checks++; if ({completion_ur_req, ur_fifo_count} !== {1'b1, 3'd2})
      $display("FAIL rmid_setup: got %b expected 1010", {completion_ur_req, ur_fifo_count}); else passed++;
    rst = 1'b1;
    tick();
    checks++; if (completion_ur_req !== 1'b0) $display("FAIL rmid_req: got %b expected 0", completion_ur_req); else passed++;
    checks++; if (ur_fifo_count !== 3'd0) $display("FAIL rmid_count: got %0d expected 0", ur_fifo_count); else passed++;
    checks++; if (dut.r_state !== ARB_IDLE) $display("FAIL rmid_state: got %0d expected %0d", dut.r_state, ARB_IDLE); else passed++;
    checks++; if (ur_in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %b expected 0", ur_in_ready); else passed++;
    rst = 1'b0;
    tick(); tick();
    checks++; if (completion_ur_req !== 1'b0) $display("FAIL rmid_no_regrant: got %b expected 0", completion_ur_req); else passed++;
  endtask

  task automatic test_simul_push_pop();
    int base = grant_log.size();
    push_ur(8'hC0, 16'h0C00);
    push_ur(8'hC1, 16'h0C01);
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 10 && completion_ur_req !== 1'b1; n++) tick();
      checks++; if (completion_ur_req !== 1'b1) $display("FAIL spp_wait_%0d: got %b expected 1", k, completion_ur_req); else passed++;
      ur_in_valid = 1'b1; ur_in_tag = 8'hC2 + 8'(k); completion_ur_done = 1'b1;
      tick();
      ur_in_valid = 1'b0; completion_ur_done = 1'b0;
      checks++; if (ur_fifo_count !== 3'd2) $display("FAIL spp_count_%0d: got %0d expected 2", k, ur_fifo_count); else passed++;
    end
    responder(base + 6, 0, 80);
    checks++; if (grant_log.size() - base !== 6) $display("FAIL spp_grants: got %0d expected 6", grant_log.size() - base); else passed++;
    for (int i = 0; i < 6; i++) begin
      if (base + i < grant_log.size()) begin
        checks++; if (grant_log[base + i] !== 32'hC0 + i)
          $display("FAIL spp_order_%0d: got %0h expected %0h", i, grant_log[base + i], 32'hC0 + i); else passed++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rd_cpl_valid = 1'b0; rd_cpl_data = '0; ur_in_valid = 1'b0;
    ur_in_tag = '0; ur_in_lower_addr = 7'h15; ur_in_first_be = 4'hC;
    ur_in_requester_id = '0; ur_in_tc = 3'd2; ur_in_attr = 3'd5;
    axi_cpld_ready = 1'b0; completion_ur_done = 1'b0;
    test_reset();
    test_single_read();
    test_single_ur();
    test_contention();
    test_full_queue();
    test_reset_mid_ur();
    test_simul_push_pop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cpl_req_arbiter.md
CPL_REQ_ARBITER -- requirements
Module: cpl_req_arbiter

Interface
REQ-001 SHALL have parameter TCQ, default 1, register clock-to-out delay for simulation.
REQ-002 SHALL have parameter UR_FIFO_DEPTH, default 4, pending-UR queue depth (power of 2, 2..16).
REQ-003 SHALL have port axis_clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port axis_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports rd_cpl_valid in 1, rd_cpl_ready out 1, rd_cpl_data in 64; upstream read-completion payload.
REQ-006 SHALL have ports ur_in_valid in 1, ur_in_ready out 1; upstream UR request handshake.
REQ-007 SHALL have ports ur_in_tag in 8, ur_in_lower_addr in 7, ur_in_first_be in 4, ur_in_requester_id in 16, ur_in_tc in 3, ur_in_attr in 3; UR fields (41 bits total).
REQ-008 SHALL have ports axi_cpld_valid out 1, axi_cpld_ready in 1, axi_cpld_data out 64; to completion TLP generator.
REQ-009 SHALL have ports completion_ur_req out 1, completion_ur_done in 1, plus completion_ur_tag/lower_addr/first_be/requester_id/tc/attr out (8/7/4/16/3/3); UR handshake to TLP generator.
REQ-010 SHALL have port ur_fifo_count  out  $clog2(UR_FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-011 SHALL accept a UR entry when ur_in_valid & ur_in_ready; ur_in_ready = !full, held 0 while axis_rst is high.
REQ-012 SHALL use FSM states ARB_IDLE, ARB_RD, ARB_UR, ARB_UR_RELEASE.
REQ-013 ARB_IDLE: rd_cpl_valid only -> ARB_RD; queue non-empty only -> ARB_UR; both -> grant the source not granted last (last_grant flag, reset value = UR, so read wins first tie); neither -> stay.
REQ-014 ARB_RD: axi_cpld_valid = rd_cpl_valid, axi_cpld_data = rd_cpl_data, rd_cpl_ready = axi_cpld_ready (combinational pass-through); on axi_cpld_valid & axi_cpld_ready -> ARB_IDLE, last_grant <= RD.
REQ-015 Outside ARB_RD, axi_cpld_valid and rd_cpl_ready SHALL be 0.
REQ-016 ARB_UR: completion_ur_req registered high, completion_ur_* driven from queue head and stable until exit; on completion_ur_done = 1 -> pop head, drop completion_ur_req next cycle, last_grant <= UR, -> ARB_UR_RELEASE.
REQ-017 ARB_UR_RELEASE: completion_ur_req = 0; stay until completion_ur_done = 0, then -> ARB_IDLE (no re-request while done is high).
REQ-018 SHALL NOT enter ARB_UR while completion_ur_done is high.
REQ-019 Grant decision to first downstream assertion: 1 cycle (registered FSM); back-to-back grants SHALL pass through ARB_IDLE for one cycle.
REQ-020 Simultaneous push and pop SHALL leave ur_fifo_count unchanged; pointers wrap modulo UR_FIFO_DEPTH.
REQ-021 No UR entry SHALL be lost or duplicated; when the queue is full, pushes are refused by backpressure only.
REQ-022 Unknown FSM encoding SHALL recover to ARB_IDLE next cycle.

Reset
REQ-023 On axis_rst: FSM = ARB_IDLE, queue emptied (count 0, pointers 0), completion_ur_req = 0, axi_cpld_valid = 0, rd_cpl_ready = 0, ur_in_ready = 0, last_grant = UR.
REQ-024 Reset mid-operation SHALL discard the in-flight grant and all queued URs; outputs return to reset values on the next edge.
REQ-025 completion_ur_* field outputs are don't-care while completion_ur_req = 0.

Structure
REQ-026 Package cpl_arb_pkg SHALL hold FSM state encodings, grant-source enum (RD/UR) and UR_ENTRY_W = 41 with field offsets.
REQ-027 Queue SHALL be a sub-module ur_req_fifo (synchronous, registered pointers, first-word-fall-through head).
REQ-028 Arbiter FSM and pass-through muxing SHALL live in cpl_req_arbiter.

Verification
REQ-029 Single read: rd_cpl_valid with data 64'h0123_4567_89AB_CDEF, axi_cpld_ready high 2 cycles later -> exactly one downstream beat with that data, rd_cpl_ready pulses once, FSM back in ARB_IDLE.
REQ-030 Single UR: tag 8'h5A, requester_id 16'hBEEF, done pulsed 1 cycle after 3 cycles -> completion_ur_req high until done, fields stable, count 1 -> 0, no re-request while done is high.
REQ-031 Contention: read pending and 3 URs queued -> grant order RD, UR, RD (if re-asserted), UR, UR; alternation holds.
REQ-032 Full queue: push 5 URs at depth 4 with no done -> ur_in_ready 0 after 4th, count = 4, 5th accepted only after first pop; all 5 tags emerge in order.
REQ-033 Reset mid-UR: axis_rst during ARB_UR with 2 queued -> next cycle completion_ur_req = 0, count = 0, ARB_IDLE.
REQ-034 Simultaneous push/pop at count 2 -> count stays 2, FIFO order preserved across pointer wrap.
